// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit signed shift-add multiplier datapath and its controller.
// Strobe priorities are expressed as ranks so the controller and datapath agree on ordering.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int EXT_W = WIDTH + 1;

    // A/X strobe ranks: a higher rank wins when several strobes arrive in one cycle.
    localparam int PRIO_SHIFT = 0;
    localparam int PRIO_ADD   = 1;
    localparam int PRIO_SUB   = 2;
    localparam int PRIO_CLR   = 3;
    localparam int AX_PRIO_N  = 4;

    // B strobe ranks.
    localparam int PRIO_B_SHIFT = 0;
    localparam int PRIO_LD_B    = 1;
    localparam int B_PRIO_N     = 2;

    typedef enum logic [2:0] {
        AX_HOLD  = 3'd0,
        AX_CLR   = 3'd1,
        AX_SUB   = 3'd2,
        AX_ADD   = 3'd3,
        AX_SHIFT = 3'd4
    } ax_op_e;

    typedef enum logic [1:0] {
        B_HOLD  = 2'd0,
        B_LOAD  = 2'd1,
        B_SHIFT = 2'd2
    } b_op_e;

    typedef struct packed {
        logic clr_a;
        logic ld_b;
        logic add_en;
        logic sub_en;
        logic shift_en;
    } strobe_t;

    function automatic logic [EXT_W-1:0] sign_ext(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    function automatic ax_op_e prio_to_ax(input int p);
        ax_op_e op;
        case (p)
            PRIO_CLR:   op = AX_CLR;
            PRIO_SUB:   op = AX_SUB;
            PRIO_ADD:   op = AX_ADD;
            PRIO_SHIFT: op = AX_SHIFT;
            default:    op = AX_HOLD;
        endcase
        return op;
    endfunction

    function automatic b_op_e prio_to_b(input int p);
        b_op_e op;
        case (p)
            PRIO_LD_B:    op = B_LOAD;
            PRIO_B_SHIFT: op = B_SHIFT;
            default:      op = B_HOLD;
        endcase
        return op;
    endfunction

    // Scan ranks low to high so the highest asserted rank is the one that sticks.
    function automatic ax_op_e decode_ax(input strobe_t s);
        logic [AX_PRIO_N-1:0] req;
        ax_op_e               op;
        req             = 4'b0000;
        req[PRIO_CLR]   = s.clr_a;
        req[PRIO_SUB]   = s.sub_en;
        req[PRIO_ADD]   = s.add_en;
        req[PRIO_SHIFT] = s.shift_en;
        op              = AX_HOLD;
        for (int p = 0; p < AX_PRIO_N; p++) begin
            if (req[p]) begin
                op = prio_to_ax(p);
            end
        end
        return op;
    endfunction

    function automatic b_op_e decode_b(input strobe_t s);
        logic [B_PRIO_N-1:0] req;
        b_op_e               op;
        req               = 2'b00;
        req[PRIO_LD_B]    = s.ld_b;
        req[PRIO_B_SHIFT] = s.shift_en;
        op                = B_HOLD;
        for (int p = 0; p < B_PRIO_N; p++) begin
            if (req[p]) begin
                op = prio_to_b(p);
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/add_sub9.sv
// Combinational 9-bit two's-complement adder/subtractor; carry out of bit 8 is dropped.
module add_sub9
    import mult_pkg::*;
(
    input  logic [EXT_W-1:0] a,
    input  logic [EXT_W-1:0] s,
    input  logic             sub,
    output logic [EXT_W-1:0] sum
);

    logic [EXT_W-1:0] w_s_eff;

    // Subtract as a + ~s + 1, sharing one adder for both operations.
    always_comb begin
        w_s_eff = s;
        if (sub) begin
            w_s_eff = ~s;
        end else begin
            w_s_eff = s;
        end
        sum = a + w_s_eff + {{(EXT_W-1){1'b0}}, sub};
    end

endmodule

// File: rtl/mult_datapath.sv
// A/B/X register datapath for a signed shift-add multiplier; all sequencing lives in the controller.
// {A,B} holds the 16-bit product, X is the sign extension carried into A during shifts.
module mult_datapath
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             clr_a,
    input  logic             ld_b,
    input  logic             add_en,
    input  logic             sub_en,
    input  logic             shift_en,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             x_val,
    output logic             bout
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_x;

    strobe_t          w_strobe;
    ax_op_e           w_ax_op;
    b_op_e            w_b_op;
    logic             w_sub;
    logic [EXT_W-1:0] w_a_ext;
    logic [EXT_W-1:0] w_s_ext;
    logic [EXT_W-1:0] w_sum;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_x_next;

    // Resolve concurrent strobes into one A/X action and one B action.
    always_comb begin
        w_strobe = '{clr_a: clr_a, ld_b: ld_b, add_en: add_en,
                     sub_en: sub_en, shift_en: shift_en};
        w_ax_op  = decode_ax(w_strobe);
        w_b_op   = decode_b(w_strobe);
        w_sub    = (w_ax_op == AX_SUB);
        w_a_ext  = sign_ext(r_a);
        w_s_ext  = sign_ext(sw);
    end

    add_sub9 u_add_sub9 (
        .a   (w_a_ext),
        .s   (w_s_ext),
        .sub (w_sub),
        .sum (w_sum)
    );

    // Next-state selection for A and X.
    always_comb begin
        w_a_next = r_a;
        w_x_next = r_x;
        case (w_ax_op)
            AX_CLR: begin
                w_a_next = {WIDTH{1'b0}};
                w_x_next = 1'b0;
            end
            AX_SUB, AX_ADD: begin
                w_x_next = w_sum[EXT_W-1];
                w_a_next = w_sum[WIDTH-1:0];
            end
            AX_SHIFT: begin
                w_a_next = {r_x, r_a[WIDTH-1:1]};
                w_x_next = r_x;
            end
            default: begin
                w_a_next = r_a;
                w_x_next = r_x;
            end
        endcase
    end

    // Next-state selection for B; a shift pulls in A[0] as it was before this edge.
    always_comb begin
        w_b_next = r_b;
        case (w_b_op)
            B_LOAD:  w_b_next = sw;
            B_SHIFT: w_b_next = {r_a[0], r_b[WIDTH-1:1]};
            default: w_b_next = r_b;
        endcase
    end

    // Datapath registers; reset clears the partial product immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a <= {WIDTH{1'b0}};
            r_b <= {WIDTH{1'b0}};
            r_x <= 1'b0;
        end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            r_x <= w_x_next;
        end
    end

    assign a_val = r_a;
    assign b_val = r_b;
    assign x_val = r_x;
    assign bout  = r_b[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: a driver pushes expected register state, a monitor compares.
module tb_mult_datapath;

    localparam logic [4:0] ST_IDLE = 5'b00000;
    localparam logic [4:0] ST_CLR  = 5'b10000;
    localparam logic [4:0] ST_LD   = 5'b01000;
    localparam logic [4:0] ST_ADD  = 5'b00100;
    localparam logic [4:0] ST_SUB  = 5'b00010;
    localparam logic [4:0] ST_SH   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sw;
    logic       clr_a, ld_b, add_en, sub_en, shift_en;
    logic [7:0] a_val, b_val;
    logic       x_val, bout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic       m_x = 1'b0;

    mult_datapath dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw),
        .clr_a    (clr_a),
        .ld_b     (ld_b),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .a_val    (a_val),
        .b_val    (b_val),
        .x_val    (x_val),
        .bout     (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: registers as signed integers; add/sub done with plain integer arithmetic modulo 512.
    function automatic void model_step(input logic [4:0] st, input logic [7:0] s);
        logic       old_a0;
        int         v;
        logic [8:0] w;
        old_a0 = m_a[0];
        v      = 0;
        if (!reset_n) begin
            m_a = 8'h00;
            m_b = 8'h00;
            m_x = 1'b0;
            return;
        end
        if (st[4]) begin
            m_a = 8'h00;
            m_x = 1'b0;
        end else if (st[1] || st[2]) begin
            v = st[1] ? int'($signed(m_a)) - int'($signed(s))
                      : int'($signed(m_a)) + int'($signed(s));
            w   = v[8:0];
            m_x = w[8];
            m_a = w[7:0];
        end else if (st[0]) begin
            m_a = {m_x, m_a[7:1]};
        end
        if (st[3]) begin
            m_b = s;
        end else if (st[0]) begin
            m_b = {old_a0, m_b[7:1]};
        end
    endfunction

    task automatic step(input logic [4:0] st, input logic [7:0] s);
        exp_t e;
        @(negedge clk);
        {clr_a, ld_b, add_en, sub_en, shift_en} = st;
        sw = s;
        model_step(st, s);
        e.a = m_a;
        e.b = m_b;
        e.x = m_x;
        q.push_back(e);
    endtask

    // Full multiply driven by the bench acting as controller, from its own copy of the multiplier.
    task automatic mult(input logic [7:0] s, input logic [7:0] m);
        int prod;
        step(ST_LD, m);
        step(ST_CLR, s);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                step((i == 7) ? ST_SUB : ST_ADD, s);
            end
            step(ST_SH, s);
        end
        @(posedge clk);
        #2;
        prod = int'($signed(s)) * int'($signed(m));
        check("product", {16'h0000, a_val, b_val}, {16'h0000, prod[15:0]});
    endtask

    // Monitor: the datapath presents its state every cycle; compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("a_val", {24'h0, a_val}, {24'h0, e.a});
                check("b_val", {24'h0, b_val}, {24'h0, e.b});
                check("x_val", {31'h0, x_val}, {31'h0, e.x});
                check("bout",  {31'h0, bout},  {31'h0, e.b[0]});
            end
        end
    end

    task automatic pulse_reset(input string name);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_x = 1'b0;
        #1;
        check({name, "_a"}, {24'h0, a_val}, 32'h0);
        check({name, "_b"}, {24'h0, b_val}, 32'h0);
        check({name, "_x"}, {31'h0, x_val}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(5'($urandom_range(1, 31)), 8'($urandom));
        end
        step(ST_IDLE, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sw = 8'h00;
        {clr_a, ld_b, add_en, sub_en, shift_en} = ST_IDLE;
        #1;
        check("reset_a", {24'h0, a_val}, 32'h0);
        check("reset_b", {24'h0, b_val}, 32'h0);
        check("reset_x", {31'h0, x_val}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(ST_IDLE, 8'hA5);

        // Async reset with A=0x55, B=0xAA loaded.
        step(ST_CLR, 8'h00);
        step(ST_ADD, 8'h55);
        step(ST_LD, 8'hAA);
        pulse_reset("async_rst");

        // Overflow across the sign boundary into X.
        step(ST_CLR, 8'h00);
        step(ST_ADD, 8'h7F);
        step(ST_ADD, 8'h01);
        @(posedge clk); #2;
        check("add_ovf_a", {24'h0, a_val}, 32'h80);
        check("add_ovf_x", {31'h0, x_val}, 32'h0);
        step(ST_SUB, 8'h01);
        @(posedge clk); #2;
        check("sub_ovf_a", {24'h0, a_val}, 32'h7F);
        check("sub_ovf_x", {31'h0, x_val}, 32'h1);

        mult(8'hFD, 8'h07);
        check("m3x7_ab", {16'h0, a_val, b_val}, 32'hFFEB);
        check("m3x7_x", {31'h0, x_val}, 32'h1);
        mult(8'h80, 8'h80);
        check("m128sq_ab", {16'h0, a_val, b_val}, 32'h4000);
        check("m128sq_x", {31'h0, x_val}, 32'h0);

        // clr_a beats add_en; B still shifts in the pre-clear A[0].
        step(ST_CLR, 8'h00);
        step(ST_ADD, 8'h03);
        step(ST_LD, 8'h0F);
        step(ST_CLR | ST_ADD | ST_SH, 8'h11);
        @(posedge clk); #2;
        check("clr_prio_a", {24'h0, a_val}, 32'h0);
        check("clr_prio_x", {31'h0, x_val}, 32'h0);
        check("clr_prio_b", {24'h0, b_val}, 32'h87);

        // ld_b beats B shift while A/X still shift.
        step(ST_CLR, 8'h00);
        step(ST_ADD, 8'h81);
        step(ST_LD | ST_SH, 8'h3C);
        @(posedge clk); #2;
        check("ldsh_a", {24'h0, a_val}, 32'hC0);
        check("ldsh_x", {31'h0, x_val}, 32'h1);
        check("ldsh_b", {24'h0, b_val}, 32'h3C);

        // Reset mid-multiply, then a fresh multiply must work.
        step(ST_LD, 8'h5B);
        step(ST_CLR, 8'hC3);
        step(ST_ADD, 8'hC3);
        step(ST_SH, 8'hC3);
        pulse_reset("mid_rst");
        mult(8'h06, 8'hF9);

        for (int i = 0; i < 12; i++) begin
            mult(8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 250; i++) begin
            step({($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0)}, 8'($urandom));
        end
        step(ST_IDLE, 8'h00);
        step(ST_IDLE, 8'hFF);
        @(posedge clk); #3;
        check("queue_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
